fifo216_unpack: RTL

// - Read-side consumer of the 216-bit wide block-RAM FIFO (standard mode, registered output, single clock).
// - Hides the fixed FIFO read latency behind a credit-controlled skid buffer.
// - Serializes each 216-bit word into SLICES beats of 72 bits with valid/ready, least significant slice first.
// - Feeds the 72-bit datapath of the next decoder stage.

---
 rtl/fifo216_unpack_pkg.sv | 29 ++
 rtl/fifo216_unpack_ringbuf.sv | 56 +++++
 rtl/fifo216_unpack.sv | 90 +++++++++
 3 files changed

// File: rtl/fifo216_unpack_pkg.sv
// Shared constants and helpers for the 216-bit FIFO read-side unpacker.
// IN_WIDTH, OUT_WIDTH, SLICES and RD_LATENCY must stay in step with the FIFO216 instantiation.
package fifo216_unpack_pkg;

  localparam int unsigned IN_WIDTH   = 216;
  localparam int unsigned OUT_WIDTH  = 72;
  localparam int unsigned SLICES     = 3;
  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned BUF_DEPTH  = 4;

  localparam int unsigned PTR_W   = $clog2(BUF_DEPTH);
  // One extra bit so count (0..BUF_DEPTH) plus in-flight reads never wraps in the credit compare.
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned SLICE_W = $clog2(SLICES);

  typedef logic [IN_WIDTH-1:0]  word_t;
  typedef logic [OUT_WIDTH-1:0] beat_t;

  // Number of reads still travelling through the FIFO output pipeline.
  function automatic logic [CNT_W-1:0] popcount_inflight(input logic [RD_LATENCY-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fifo216_unpack_ringbuf.sv
// BUF_DEPTH x IN_WIDTH register ring with one write port, one read port and an occupancy count.
module unpack_ringbuf
  import fifo216_unpack_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  word_t            wr_data,
  input  logic             rd_en,
  output word_t            rd_data,
  output logic [CNT_W-1:0] count
);

  word_t            mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Occupancy update; a simultaneous write and read leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally at PTR_W bits; flush empties the ring.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/fifo216_unpack.sv
// Read-side consumer of the 216-bit block-RAM FIFO. Issues credit-limited reads, absorbs the
// fixed read latency in a small ring, and emits each word as SLICES beats, low slice first.
module fifo216_unpack
  import fifo216_unpack_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  output logic                 fifo_rd_en,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  input  logic                 dout_ready,
  output logic [CNT_W-1:0]     words_avail
);

  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [SLICE_W-1:0]    slice_q, slice_d;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      outstanding;
  word_t                 rd_word;
  beat_t                 beat_sel;
  logic                  capture, accept, last_slice, pop;

  // Credit counts buffered words plus reads not yet returned; a same-cycle pop frees nothing.
  assign outstanding = count + popcount_inflight(inflight_q);
  assign fifo_rd_en  = !fifo_empty && !flush && (outstanding < CNT_W'(BUF_DEPTH));

  assign capture    = inflight_q[RD_LATENCY-1] && !flush;
  assign dout_valid = (count != '0);
  assign last_slice = (slice_q == SLICE_W'(SLICES - 1));
  assign accept     = dout_valid && dout_ready;
  assign pop        = accept && last_slice && !flush;

  unpack_ringbuf u_ringbuf (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (capture),
    .wr_data (fifo_dout),
    .rd_en   (pop),
    .rd_data (rd_word),
    .count   (count)
  );

  // Shift the read strobe along so its tail lines up with the returning FIFO data.
  always_comb begin
    inflight_d = {inflight_q[RD_LATENCY-2:0], fifo_rd_en};
  end

  // Advance through the slices of the head word on each accepted beat.
  always_comb begin
    slice_d = slice_q;
    if (accept) begin
      slice_d = last_slice ? '0 : slice_q + SLICE_W'(1);
    end
  end

  // Flush clears in-flight reads so late FIFO returns are never captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      slice_q    <= '0;
    end else if (flush) begin
      inflight_q <= '0;
      slice_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      slice_q    <= slice_d;
    end
  end

  // Select the current slice of the head word.
  always_comb begin
    beat_sel = '0;
    for (int i = 0; i < int'(SLICES); i++) begin
      if (slice_q == SLICE_W'(i)) begin
        beat_sel = rd_word[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Gate with valid so the unreset storage never shows on dout.
  assign dout        = dout_valid ? beat_sel : '0;
  assign dout_last   = dout_valid && last_slice;
  assign words_avail = count;

endmodule
